lsu_req: RTL and testbench

//  EX-stage data-memory request unit: turns EX load/store info into data-RAM requests with handshake.

---
 rtl/lsu_req_pkg.sv | 18 +
 rtl/lsu_req_if.sv | 13 +
 rtl/lsu_store_align.sv | 32 +++
 rtl/lsu_req.sv | 100 ++++++++++
 tb/tb_lsu_req.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_req_pkg.sv
// Shared constants and helpers for the EX-stage load/store request unit.
package lsu_req_pkg;
  localparam int XLEN         = 32;
  localparam int MEM_OP_WIDTH = 3;
  localparam int MEM_OP_BYTE  = 0;
  localparam int MEM_OP_HALF  = 1;
  localparam int MEM_OP_WORD  = 2;

  localparam logic [3:0] EXC_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] EXC_STORE_MISALIGN = 4'd6;

  typedef logic [MEM_OP_WIDTH-1:0] mem_op_t;

  // Word-aligned RAM address; the byte offset travels separately to MEM.
  function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/lsu_req_if.sv
// Data-RAM request/response bus between the LSU and the data memory.
interface lsu_req_if import lsu_req_pkg::*; ();
  logic            req;
  logic            write;
  logic [XLEN-1:0] addr;
  logic [3:0]      wstrb;
  logic [XLEN-1:0] wdata;
  logic            ready;
  logic            rvalid;

  modport master (output req, write, addr, wstrb, wdata, input ready, rvalid);
  modport slave  (input req, write, addr, wstrb, wdata, output ready, rvalid);
endinterface

// File: rtl/lsu_store_align.sv
// Combinational access-size decode: byte strobes, lane-replicated store data, misalignment.
module lsu_store_align import lsu_req_pkg::*; (
  input  mem_op_t         op,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] data_in,
  output logic [3:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic            misaligned
);
  assign misaligned = (op[MEM_OP_HALF] & addr_lo[0]) |
                      (op[MEM_OP_WORD] & (addr_lo != 2'b00));

  always_comb begin
    wstrb = 4'b0000;
    if (op[MEM_OP_WORD])
      wstrb = 4'b1111;
    else if (op[MEM_OP_HALF])
      wstrb = 4'b0011 << {addr_lo[1], 1'b0};
    else if (op[MEM_OP_BYTE])
      wstrb = 4'b0001 << addr_lo;
  end

  // Each lane picks its source byte so the RAM can write whichever lanes are strobed.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN/8; gi++) begin : g_lane
      assign wdata[8*gi +: 8] = op[MEM_OP_WORD] ? data_in[8*gi +: 8] :
                                op[MEM_OP_HALF] ? data_in[8*(gi%2) +: 8] :
                                                  data_in[7:0];
    end
  endgenerate
endmodule

// File: rtl/lsu_req.sv
// EX-stage data-memory request unit: issues RAM requests, tracks outstanding loads
// and discards returns of loads that were flushed after acceptance.
module lsu_req import lsu_req_pkg::*; #(
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic             ex_mem_write,
  input  mem_op_t          ex_mem_opcode,
  input  logic [XLEN-1:0]  ex_addr,
  input  logic [XLEN-1:0]  ex_wdata,
  input  logic             ex_flush,
  input  logic             mem_pipe_ready,
  output logic             lsu_ready,
  output logic             lsu_exc_pending,
  output logic [3:0]       lsu_exc_code,
  output logic [XLEN-1:0]  lsu_exc_tval,
  output logic [1:0]       lsu_byte_addr,
  lsu_req_if.master        dram,
  output logic             lsu_rvalid
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             accepted_reg, accepted_next;
  logic [CNT_W-1:0] out_cnt_reg, out_cnt_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;

  logic             mem, misaligned, issue, handshake, load_hs, advance, ret;
  logic [3:0]       strb;
  logic [XLEN-1:0]  aligned_wdata;

  lsu_store_align u_align (
    .op         (ex_mem_opcode),
    .addr_lo    (ex_addr[1:0]),
    .data_in    (ex_wdata),
    .wstrb      (strb),
    .wdata      (aligned_wdata),
    .misaligned (misaligned)
  );

  assign mem       = ex_valid & (ex_mem_read | ex_mem_write) & ~ex_flush;
  // Pending drops block new requests so every return maps to the oldest load.
  assign issue     = mem & ~misaligned & ~accepted_reg & ~rst &
                     (ex_mem_write | (out_cnt_reg < CNT_MAX)) &
                     (drop_cnt_reg == '0);
  assign handshake = issue & dram.ready;
  assign load_hs   = handshake & ~ex_mem_write;
  assign lsu_ready = ~mem | misaligned | accepted_reg | handshake;
  assign advance   = ex_valid & lsu_ready & mem_pipe_ready;
  assign ret       = dram.rvalid & (out_cnt_reg != '0);

  assign dram.req   = issue;
  assign dram.write = ex_mem_write;
  assign dram.addr  = word_addr(ex_addr);
  assign dram.wstrb = ex_mem_write ? strb : 4'b0000;
  assign dram.wdata = aligned_wdata;

  assign lsu_exc_pending = mem & misaligned & ~rst;
  assign lsu_exc_code    = ex_mem_write ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
  assign lsu_exc_tval    = ex_addr;
  assign lsu_byte_addr   = ex_addr[1:0];
  assign lsu_rvalid      = dram.rvalid & (drop_cnt_reg == '0) & ~rst;

  always_comb begin
    accepted_next = accepted_reg;
    if (ex_flush || advance)
      accepted_next = 1'b0;
    else if (handshake && !mem_pipe_ready)
      accepted_next = 1'b1;

    out_cnt_next = out_cnt_reg;
    if (load_hs && !ret)
      out_cnt_next = out_cnt_reg + CNT_ONE;
    else if (!load_hs && ret)
      out_cnt_next = out_cnt_reg - CNT_ONE;

    // A flush discards every load not yet returned, whether still in EX or already in MEM.
    drop_cnt_next = drop_cnt_reg;
    if (ex_flush)
      drop_cnt_next = out_cnt_next;
    else if (ret && (drop_cnt_reg != '0))
      drop_cnt_next = drop_cnt_reg - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      accepted_reg <= 1'b0;
      out_cnt_reg  <= '0;
      drop_cnt_reg <= '0;
    end else begin
      accepted_reg <= accepted_next;
      out_cnt_reg  <= out_cnt_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end
endmodule

// File: tb/tb_lsu_req.sv
// Self-checking bench for lsu_req: vector table, directed multi-cycle sequences,
// and randomized traffic against a queue-based reference model.
module tb_lsu_req;
  import lsu_req_pkg::*;

  localparam int MAX = 2;
  localparam logic [2:0] OP_B = 3'b001;
  localparam logic [2:0] OP_H = 3'b010;
  localparam logic [2:0] OP_W = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_mem_read, ex_mem_write, ex_flush, mem_pipe_ready;
  logic [2:0]  ex_mem_opcode;
  logic [31:0] ex_addr, ex_wdata;
  logic        lsu_ready, lsu_exc_pending, lsu_rvalid;
  logic [3:0]  lsu_exc_code;
  logic [31:0] lsu_exc_tval;
  logic [1:0]  lsu_byte_addr;

  lsu_req_if dram_if();

  lsu_req #(.MAX_OUTSTANDING(MAX)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_mem_opcode   (ex_mem_opcode),
    .ex_addr         (ex_addr),
    .ex_wdata        (ex_wdata),
    .ex_flush        (ex_flush),
    .mem_pipe_ready  (mem_pipe_ready),
    .lsu_ready       (lsu_ready),
    .lsu_exc_pending (lsu_exc_pending),
    .lsu_exc_code    (lsu_exc_code),
    .lsu_exc_tval    (lsu_exc_tval),
    .lsu_byte_addr   (lsu_byte_addr),
    .dram            (dram_if),
    .lsu_rvalid      (lsu_rvalid)
  );

  always #5 clk = ~clk;

  int hs_cnt = 0;
  always @(posedge clk) if (dram_if.req && dram_if.ready) hs_cnt <= hs_cnt + 1;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic set_ex(input bit v, input bit r, input bit w, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] d);
    ex_valid = v; ex_mem_read = r; ex_mem_write = w;
    ex_mem_opcode = op; ex_addr = a; ex_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_req;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_exc;
    logic [3:0]  exp_code;
  } vec_t;

  vec_t tbl[8];

  // Reference model state for the random phase
  bit          q[$];
  bit          done, cv, cr, cw;
  logic [2:0]  cop;
  logic [31:0] caddr, cdata;

  task automatic new_instr();
    cv = ($urandom_range(0, 4) != 0);
    cw = $urandom_range(0, 1);
    cr = !cw && ($urandom_range(0, 5) != 0);
    cop = 3'b001 << $urandom_range(0, 2);
    caddr = {$urandom_range(0, 255), 2'b00} + 32'($urandom_range(0, 3));
    cdata = $urandom;
  endtask

  initial begin
    int size, hs_before;
    bit fl, rv, dr, mpr, mem, mis, anydrop, exp_req, hs, exp_ready, adv;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, tmp;

    tbl[0] = '{1'b1, OP_W, 32'h100, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 4'd0};
    tbl[1] = '{1'b1, OP_B, 32'h103, 32'h0000005A, 1'b1, 4'h8, 32'h5A5A5A5A, 1'b0, 4'd0};
    tbl[2] = '{1'b1, OP_H, 32'h102, 32'h00001234, 1'b1, 4'hC, 32'h12341234, 1'b0, 4'd0};
    tbl[3] = '{1'b0, OP_W, 32'h102, 32'h00000000, 1'b0, 4'h0, 32'h0,       1'b1, 4'd4};
    tbl[4] = '{1'b1, OP_H, 32'h101, 32'h0000BEEF, 1'b0, 4'h0, 32'h0,       1'b1, 4'd6};
    tbl[5] = '{1'b1, OP_B, 32'h101, 32'h1122337F, 1'b1, 4'h2, 32'h7F7F7F7F, 1'b0, 4'd0};
    tbl[6] = '{1'b1, OP_H, 32'h100, 32'hAABBCCDD, 1'b1, 4'h3, 32'hCCDDCCDD, 1'b0, 4'd0};
    tbl[7] = '{1'b1, OP_W, 32'h10E, 32'h01020304, 1'b0, 4'h0, 32'h0,       1'b1, 4'd6};

    // Reset: outputs quiet even with live inputs
    rst = 1'b1; ex_flush = 1'b0; mem_pipe_ready = 1'b1;
    dram_if.ready = 1'b1; dram_if.rvalid = 1'b1;
    set_ex(1, 1, 0, OP_W, 32'h200, 0);
    @(negedge clk); #1;
    check("rst_req", 32'(dram_if.req), 0);
    check("rst_rvalid", 32'(lsu_rvalid), 0);
    set_ex(1, 1, 0, OP_W, 32'h202, 0); #1;
    check("rst_exc", 32'(lsu_exc_pending), 0);
    step();
    rst = 1'b0; dram_if.rvalid = 1'b0; set_ex(0, 0, 0, OP_W, 0, 0);
    step();

    // Single-cycle vectors
    for (int i = 0; i < 8; i++) begin
      set_ex(1, !tbl[i].wr, tbl[i].wr, tbl[i].op, tbl[i].addr, tbl[i].data);
      #1;
      $display("vec %0d: wr=%0b op=%b addr=0x%03h req=%0b exc=%0b",
               i, tbl[i].wr, tbl[i].op, tbl[i].addr, dram_if.req, lsu_exc_pending);
      check($sformatf("v%0d_req", i), 32'(dram_if.req), 32'(tbl[i].exp_req));
      check($sformatf("v%0d_exc", i), 32'(lsu_exc_pending), 32'(tbl[i].exp_exc));
      check($sformatf("v%0d_ready", i), 32'(lsu_ready), 1);
      check($sformatf("v%0d_byte", i), 32'(lsu_byte_addr), 32'(tbl[i].addr[1:0]));
      if (tbl[i].exp_req) begin
        check($sformatf("v%0d_strb", i), 32'(dram_if.wstrb), 32'(tbl[i].exp_strb));
        check($sformatf("v%0d_wdata", i), dram_if.wdata, tbl[i].exp_wdata);
        check($sformatf("v%0d_addr", i), dram_if.addr, {tbl[i].addr[31:2], 2'b00});
      end
      if (tbl[i].exp_exc) begin
        check($sformatf("v%0d_code", i), 32'(lsu_exc_code), 32'(tbl[i].exp_code));
        check($sformatf("v%0d_tval", i), lsu_exc_tval, tbl[i].addr);
      end
      step();
    end
    set_ex(0, 0, 0, OP_W, 0, 0);
    step();

    // LW with RAM stalled 3 cycles
    $display("seq: load with ram stall");
    hs_before = hs_cnt;
    dram_if.ready = 1'b0;
    set_ex(1, 1, 0, OP_W, 32'h200, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      check("stall_req", 32'(dram_if.req), 1);
      check("stall_addr", dram_if.addr, 32'h200);
      check("stall_ready", 32'(lsu_ready), 0);
      step();
    end
    dram_if.ready = 1'b1; #1;
    check("stall_hs_ready", 32'(lsu_ready), 1);
    step();
    set_ex(0, 0, 0, OP_W, 0, 0);
    check("stall_one_hs", 32'(hs_cnt - hs_before), 1);
    dram_if.rvalid = 1'b1; #1;
    check("stall_rvalid", 32'(lsu_rvalid), 1);
    step();
    dram_if.rvalid = 1'b0;

    // Handshake while EX->MEM is blocked for two cycles
    $display("seq: accepted with mem pipe stalled");
    hs_before = hs_cnt;
    mem_pipe_ready = 1'b0;
    set_ex(1, 1, 0, OP_B, 32'h301, 0); #1;
    check("acc_req0", 32'(dram_if.req), 1);
    check("acc_ready0", 32'(lsu_ready), 1);
    step();
    for (int c = 0; c < 2; c++) begin
      #1;
      check("acc_req_held", 32'(dram_if.req), 0);
      check("acc_ready_held", 32'(lsu_ready), 1);
      step();
    end
    mem_pipe_ready = 1'b1;
    step();
    set_ex(0, 0, 0, OP_W, 0, 0);
    check("acc_one_hs", 32'(hs_cnt - hs_before), 1);
    dram_if.rvalid = 1'b1; #1;
    check("acc_rvalid", 32'(lsu_rvalid), 1);
    step();
    dram_if.rvalid = 1'b0;

    // Accepted load flushed before its return
    $display("seq: flush of accepted load");
    mem_pipe_ready = 1'b0;
    set_ex(1, 1, 0, OP_W, 32'h400, 0);
    step();
    ex_flush = 1'b1; #1;
    check("fl_req_in_flush", 32'(dram_if.req), 0);
    step();
    ex_flush = 1'b0; mem_pipe_ready = 1'b1;
    set_ex(1, 1, 0, OP_W, 32'h404, 0); #1;
    check("fl_blocked_req", 32'(dram_if.req), 0);
    check("fl_blocked_ready", 32'(lsu_ready), 0);
    step();
    dram_if.rvalid = 1'b1; #1;
    check("fl_dropped", 32'(lsu_rvalid), 0);
    check("fl_req_on_drop", 32'(dram_if.req), 0);
    step();
    dram_if.rvalid = 1'b0; #1;
    check("fl_req_after", 32'(dram_if.req), 1);
    step();
    set_ex(0, 0, 0, OP_W, 0, 0);
    dram_if.rvalid = 1'b1; #1;
    check("fl_new_rvalid", 32'(lsu_rvalid), 1);
    step();
    dram_if.rvalid = 1'b0;

    // Randomized traffic against the reference model
    $display("seq: random traffic");
    rst = 1'b1; step(); rst = 1'b0;
    q.delete(); done = 0; new_instr();
    for (int c = 0; c < 3000; c++) begin
      fl  = ($urandom_range(0, 11) == 0);
      dr  = $urandom_range(0, 1);
      mpr = ($urandom_range(0, 3) != 0);
      rv  = (q.size() > 0) && ($urandom_range(0, 2) == 0);
      set_ex(cv, cr, cw, cop, caddr, cdata);
      ex_flush = fl; mem_pipe_ready = mpr;
      dram_if.ready = dr; dram_if.rvalid = rv;
      #1;
      size = cop[0] ? 1 : (cop[1] ? 2 : 4);
      mem = cv && (cr || cw) && !fl;
      mis = (caddr % size) != 0;
      anydrop = 0;
      foreach (q[k]) if (q[k]) anydrop = 1;
      exp_req = mem && !mis && !done && (cw || q.size() < MAX) && !anydrop;
      hs = exp_req && dr;
      exp_ready = !mem || mis || done || hs;
      check("r_req", 32'(dram_if.req), 32'(exp_req));
      check("r_ready", 32'(lsu_ready), 32'(exp_ready));
      check("r_exc", 32'(lsu_exc_pending), 32'(mem && mis));
      check("r_rvalid", 32'(lsu_rvalid), 32'(rv && !q[0]));
      if (mem && mis) check("r_code", 32'(lsu_exc_code), cw ? 6 : 4);
      if (exp_req && cw) begin
        e_strb = 4'(((1 << size) - 1) << (caddr % 4));
        for (int b = 0; b < 4; b++) begin
          tmp = cdata >> (8 * (b % size));
          e_wdata[8*b +: 8] = tmp[7:0];
        end
        check("r_strb", 32'(dram_if.wstrb), 32'(e_strb));
        check("r_wdata", dram_if.wdata, e_wdata);
      end
      if (exp_req && !cw) check("r_lstrb", 32'(dram_if.wstrb), 0);
      @(posedge clk);
      if (rv) void'(q.pop_front());
      if (hs && !cw) q.push_back(1'b0);
      if (fl) foreach (q[k]) q[k] = 1'b1;
      adv = cv && exp_ready && mpr;
      if (hs) done = 1;
      if (fl || adv) done = 0;
      if (fl || adv || !cv) new_instr();
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
